// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit framing, E0/F0 prefix decode, per-player held-key bitmaps.
// Latency: byte_valid/frame_err and bitmap updates appear one clk_50m cycle after the stop-bit falling edge.
// No backpressure: byte_valid is a one-cycle strobe; consumers must sample it when it pulses.
module ps2_key_matrix #(
  parameter int                  KEYS           = 5,
  parameter logic [16*KEYS-1:0]  KEYMAP         = 80'h5A4B3B4243_29231C1B1D,
  parameter int                  FILTER_LEN     = 8,
  parameter int                  TIMEOUT_CYCLES = 50000
) (
  input  logic            clk_50m,
  input  logic            rst,
  input  logic            kclk,
  input  logic            kdata,
  output logic [KEYS-1:0] player1_btns,
  output logic [KEYS-1:0] player2_btns,
  output logic            byte_valid,
  output logic [7:0]      byte_data,
  output logic            frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  logic          kclk_s1, kclk_s2, kdata_s1, kdata_s2;
  logic          kclk_f, kdata_f, kclk_prev;
  logic [7:0]    kclk_fc, kdata_fc;
  logic          fe;
  logic [3:0]    cnt;
  logic [8:0]    shift;      // {parity, data[7:0]} once nine bits are in
  logic [TW-1:0] tcnt;
  logic          brk, ext;
  logic          good;
  logic [KEYS-1:0] p1_next, p2_next;

  // Two-flop synchronisers for both asynchronous PS/2 lines, idle high.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      kclk_s1  <= 1'b1;
      kclk_s2  <= 1'b1;
      kdata_s1 <= 1'b1;
      kdata_s2 <= 1'b1;
    end else begin
      kclk_s1  <= kclk;
      kclk_s2  <= kclk_s1;
      kdata_s1 <= kdata;
      kdata_s2 <= kdata_s1;
    end
  end

  // Filtered lines flip only after FILTER_LEN consecutive samples disagree with them.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      kclk_f    <= 1'b1;
      kdata_f   <= 1'b1;
      kclk_fc   <= '0;
      kdata_fc  <= '0;
      kclk_prev <= 1'b1;
    end else begin
      kclk_prev <= kclk_f;
      if (kclk_s2 != kclk_f) begin
        if (kclk_fc == 8'(FILTER_LEN - 1)) begin
          kclk_f  <= kclk_s2;
          kclk_fc <= '0;
        end else begin
          kclk_fc <= kclk_fc + 8'd1;
        end
      end else begin
        kclk_fc <= '0;
      end
      if (kdata_s2 != kdata_f) begin
        if (kdata_fc == 8'(FILTER_LEN - 1)) begin
          kdata_f  <= kdata_s2;
          kdata_fc <= '0;
        end else begin
          kdata_fc <= kdata_fc + 8'd1;
        end
      end else begin
        kdata_fc <= '0;
      end
    end
  end

  assign fe   = kclk_prev & ~kclk_f;
  // Odd parity across data+parity, and the stop bit being sampled right now must be 1.
  assign good = (^shift) & kdata_f;

  // Candidate bitmaps if the completed byte is a plain make/break code; duplicates all update.
  always_comb begin
    p1_next = player1_btns;
    p2_next = player2_btns;
    for (int k = 0; k < KEYS; k++) begin
      if (shift[7:0] == KEYMAP[8*k +: 8])        p1_next[k] = ~brk;
      if (shift[7:0] == KEYMAP[8*(KEYS+k) +: 8]) p2_next[k] = ~brk;
    end
  end

  // Frame counter, timeout, completion strobes and prefix/bitmap state.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      cnt          <= '0;
      shift        <= '0;
      tcnt         <= '0;
      brk          <= 1'b0;
      ext          <= 1'b0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      frame_err    <= 1'b0;
      player1_btns <= '0;
      player2_btns <= '0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fe) begin
        // An edge always beats a coincident timeout expiry.
        tcnt <= '0;
        case (cnt)
          4'd0: begin
            // A high sample here is noise, not a start bit: stay idle.
            if (!kdata_f) begin
              cnt   <= 4'd1;
              shift <= '0;
            end
          end
          4'd10: begin
            cnt <= 4'd0;
            if (good) begin
              byte_valid <= 1'b1;
              byte_data  <= shift[7:0];
              if (shift[7:0] == CODE_BRK) begin
                brk <= 1'b1;
              end else if (shift[7:0] == CODE_EXT) begin
                ext <= 1'b1;
              end else begin
                brk <= 1'b0;
                ext <= 1'b0;
                // Extended keys are unmapped, so E0-prefixed codes never touch the bitmaps.
                if (!ext) begin
                  player1_btns <= p1_next;
                  player2_btns <= p2_next;
                end
              end
            end else begin
              frame_err <= 1'b1;
              brk       <= 1'b0;
              ext       <= 1'b0;
            end
          end
          default: begin
            shift <= {kdata_f, shift[8:1]};
            cnt   <= cnt + 4'd1;
          end
        endcase
      end else if (cnt != 4'd0) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          cnt       <= 4'd0;
          tcnt      <= '0;
          frame_err <= 1'b1;
          brk       <= 1'b0;
          ext       <= 1'b0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: bit-banged PS/2 frames with hand-computed bitmap expectations.
// Latency: results are checked after each frame has fully settled.
// No backpressure: pulses are counted by a negedge monitor.
module tb_ps2_key_matrix;

  localparam int KEYS = 5;
  localparam int TO   = 50000;
  localparam int H    = 20;

  logic            clk_50m = 1'b0;
  logic            rst     = 1'b1;
  logic            kclk    = 1'b1;
  logic            kdata   = 1'b1;
  logic [KEYS-1:0] player1_btns, player2_btns;
  logic            byte_valid, frame_err;
  logic [7:0]      byte_data;

  int checks = 0;
  int failures = 0;
  int bv_cnt = 0, fe_cyc = 0, fe_rise = 0;
  logic fe_prev = 1'b0;
  int bv0, fc0, fr0;

  ps2_key_matrix #(.KEYS(KEYS), .TIMEOUT_CYCLES(TO)) dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .kclk         (kclk),
    .kdata        (kdata),
    .player1_btns (player1_btns),
    .player2_btns (player2_btns),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .frame_err    (frame_err)
  );

  always #10 clk_50m = ~clk_50m;

  // Count strobe cycles and frame_err rising edges, sampled away from the active edge.
  always @(negedge clk_50m) begin
    if (byte_valid) bv_cnt++;
    if (frame_err) fe_cyc++;
    if (frame_err && !fe_prev) fe_rise++;
    fe_prev = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_50m);
    kdata = b;
    repeat (H) @(negedge clk_50m);
    kclk = 1'b0;
    repeat (H) @(negedge clk_50m);
    kclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ par_flip);
    send_bit(1'b1);
    repeat (30) @(negedge clk_50m);
  endtask

  task automatic do_reset();
    @(negedge clk_50m);
    rst = 1'b1;
    @(negedge clk_50m);
    rst = 1'b0;
  endtask

  task automatic snap();
    bv0 = bv_cnt;
    fc0 = fe_cyc;
    fr0 = fe_rise;
  endtask

  initial begin
    repeat (4) @(negedge clk_50m);
    rst = 1'b0;
    @(negedge clk_50m);
    check("reset_p1", 32'(player1_btns), 32'h0);
    check("reset_p2", 32'(player2_btns), 32'h0);
    check("reset_bv", 32'(byte_valid), 32'h0);
    check("reset_bd", 32'(byte_data), 32'h0);
    check("reset_fe", 32'(frame_err), 32'h0);

    // Reset mid-frame, then a clean 1D frame.
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    do_reset();
    repeat (10) @(negedge clk_50m);
    send_frame(8'h1D, 1'b0);
    check("midrst_p1", 32'(player1_btns), 32'h01);
    check("midrst_bv", 32'(bv_cnt - bv0), 32'd1);
    check("midrst_bd", 32'(byte_data), 32'h1D);
    check("midrst_fe", 32'(fe_cyc - fc0), 32'd0);

    // Overlapping holds, typematic repeat, and releasing.
    snap();
    send_frame(8'h1D, 1'b0);
    check("typematic_p1", 32'(player1_btns), 32'h01);
    send_frame(8'h29, 1'b0);
    check("hold2_p1", 32'(player1_btns), 32'h11);
    send_frame(8'hF0, 1'b0);
    check("brkpfx_p1", 32'(player1_btns), 32'h11);
    send_frame(8'h1D, 1'b0);
    check("release_p1", 32'(player1_btns), 32'h10);
    send_frame(8'h43, 1'b0);
    check("p2_up", 32'(player2_btns), 32'h01);
    check("p2_up_p1", 32'(player1_btns), 32'h10);
    check("overlap_bv", 32'(bv_cnt - bv0), 32'd5);
    check("overlap_fe", 32'(fe_cyc - fc0), 32'd0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h23, 1'b0);
    check("brk_not_held", 32'(player1_btns), 32'h10);

    // Parity error leaves everything alone.
    send_frame(8'hF0, 1'b0);
    send_frame(8'h29, 1'b0);
    check("rel29_p1", 32'(player1_btns), 32'h00);
    snap();
    send_frame(8'h29, 1'b1);
    check("parity_fe_cyc", 32'(fe_cyc - fc0), 32'd1);
    check("parity_fe_rise", 32'(fe_rise - fr0), 32'd1);
    check("parity_bv", 32'(bv_cnt - bv0), 32'd0);
    check("parity_p1", 32'(player1_btns), 32'h00);
    check("parity_p2", 32'(player2_btns), 32'h01);
    send_frame(8'h29, 1'b0);
    check("after_parity_p1", 32'(player1_btns), 32'h10);

    // Timeout after F0 + a partial frame; brk must be dropped.
    do_reset();
    repeat (10) @(negedge clk_50m);
    send_frame(8'hF0, 1'b0);
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk_50m);
    kdata = 1'b1;
    repeat (H) @(negedge clk_50m);
    kclk = 1'b0;
    // Edge reaches fe after 2 sync + FILTER_LEN filter cycles; fe is registered on posedge 11.
    for (int i = 1; i <= 12 + TO; i++) begin
      @(posedge clk_50m);
      #1;
      if (i == H) kclk = 1'b1;
      if (i == 10 + TO) check("to_before", 32'(frame_err), 32'h0);
      if (i == 11 + TO) check("to_at", 32'(frame_err), 32'h1);
      if (i == 12 + TO) check("to_after", 32'(frame_err), 32'h0);
    end
    check("to_fe_cyc", 32'(fe_cyc - fc0), 32'd1);
    check("to_bv", 32'(bv_cnt - bv0), 32'd0);
    send_frame(8'h5A, 1'b0);
    check("to_next_p2", 32'(player2_btns), 32'h10);
    check("to_next_p1", 32'(player1_btns), 32'h00);

    // Extended prefixes never touch the bitmaps.
    do_reset();
    repeat (10) @(negedge clk_50m);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("ext_make_p1", 32'(player1_btns), 32'h00);
    check("ext_make_p2", 32'(player2_btns), 32'h00);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("ext_brk_p1", 32'(player1_btns), 32'h00);
    check("ext_brk_p2", 32'(player2_btns), 32'h00);
    send_frame(8'h1B, 1'b0);
    check("ext_then_1b", 32'(player1_btns), 32'h02);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1D, 1'b0);
    check("ext_mapped_ignored", 32'(player1_btns), 32'h02);
    check("ext_mapped_bd", 32'(byte_data), 32'h1D);

    // Short kclk glitches are filtered out.
    snap();
    for (int g = 0; g < 3; g++) begin
      @(negedge clk_50m);
      kclk = 1'b0;
      repeat (3) @(negedge clk_50m);
      kclk = 1'b1;
      repeat (20) @(negedge clk_50m);
    end
    check("glitch_bv", 32'(bv_cnt - bv0), 32'd0);
    check("glitch_fe", 32'(fe_cyc - fc0), 32'd0);
    send_frame(8'h1D, 1'b0);
    check("glitch_then_1d", 32'(player1_btns), 32'h03);
    check("glitch_then_bv", 32'(bv_cnt - bv0), 32'd1);
    check("glitch_then_fe", 32'(fe_cyc - fc0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
